// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
// Groups the data-memory request/response bundle shared by the pipeline's
// Memory stage and the memory responder.
//
// Signals:
//   memreq   request valid; held with all request fields until ready=1
//   memwrite 1 = store, 0 = load
//   addr     32-bit byte address
//   wdata    32-bit store data
//   be       4-bit store byte enables (be[i] -> byte lane [8i+7:8i])
//   rdata    32-bit response data (registered in the responder)
//   ready    one-cycle response pulse
//   stall    memreq & ~ready, feeds the hazard unit's pipeline enables
//   err      response error flag, meaningful only in the ready cycle
//
// Modports:
//   master   processor side (drives the request, observes the response)
//   slave    responder side (observes the request, drives the response)
// ---------------------------------------------------------------------------
interface dmem_responder_if;
  logic        memreq;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ready;
  logic        stall;
  logic        err;

  modport master (
    output memreq, memwrite, addr, wdata, be,
    input  rdata, ready, stall, err
  );

  modport slave (
    input  memreq, memwrite, addr, wdata, be,
    output rdata, ready, stall, err
  );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Memory-side responder for the pipelined MIPS data-memory port. Accepts one
// load/store at a time, waits LATENCY cycles, commits the access to an
// internal word-addressed RAM and answers with a one-cycle ready pulse.
//
// Parameters:
//   DEPTH    number of 32-bit words (power of two, >= 2)
//   LATENCY  wait cycles between capture and commit (0..15)
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-low reset (asserted when 0)
//   bus      dmem_responder_if.slave: request fields in, rdata/ready/err out,
//            stall = memreq & ~ready (combinational)
//
// Configuration macro:
//   DMEM_ERR_EN  when defined, misaligned or out-of-range accesses raise err
//                in the ready cycle, suppress the store and return zero.
//                When undefined, err is 0, addresses wrap modulo DEPTH*4 and
//                misaligned addresses hit the aligned word.
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;

  logic [31:0] ram [DEPTH];

  logic          req_we;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_be;
  logic [AW-1:0] req_idx;
  logic [31:0]   old_word;
  logic [31:0]   merged_word;
  logic          commit;
  logic          commit_err;
  logic          ram_we;

  // With LATENCY=0 the commit happens on the capture edge itself, before the
  // request registers hold anything, so the commit path reads the live bus
  // fields while idle and the latched copy otherwise.
  always_comb begin
    if (state_q == S_IDLE) begin
      req_we    = bus.memwrite;
      req_addr  = bus.addr;
      req_wdata = bus.wdata;
      req_be    = bus.be;
    end else begin
      req_we    = we_q;
      req_addr  = addr_q;
      req_wdata = wdata_q;
      req_be    = be_q;
    end
  end

  assign req_idx  = req_addr[AW+1:2];
  assign old_word = ram[req_idx];

  // Byte-lane merge of the store data into the current RAM word.
  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (req_be[i]) begin
        merged_word[8*i +: 8] = req_wdata[8*i +: 8];
      end
    end
  end

`ifdef DMEM_ERR_EN
  assign commit_err = (req_addr[1:0] != 2'b00) || (req_addr >= 32'(DEPTH * 4));
`else
  // Address bits outside the word index are intentionally ignored here.
  logic unused_addr_bits;
  assign commit_err       = 1'b0;
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

  // Next-state logic: capture in IDLE, count down in WAIT, answer in RESP.
  // memreq is only sampled in IDLE; in RESP it still belongs to the request
  // being answered and must not start a new one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    commit  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.memreq) begin
          we_d    = bus.memwrite;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          be_d    = bus.be;
          if (LATENCY == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(LATENCY);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Response registers only change on the commit edge; rdata then holds.
    if (commit) begin
      ready_d = 1'b1;
      err_d   = commit_err;
      if (commit_err) begin
        rdata_d = 32'h0000_0000;
      end else if (req_we) begin
        rdata_d = merged_word;
      end else begin
        rdata_d = old_word;
      end
    end
  end

  assign ram_we = commit & req_we & ~commit_err;

  // Control and response registers. Reset aborts any request in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Storage array: not reset, contents undefined until written.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[req_idx] <= merged_word;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.stall = bus.memreq & ~ready_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Self-checking bench for dmem_responder. Two instances share the request
// fields: dut (LATENCY=2) and dut0 (LATENCY=0); sel0 routes memreq and the
// observed response to one of them. Vectors are full transactions with
// hand-computed response data, plus hand-written sequences for memreq
// dropping during WAIT and reset in the middle of a store.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  typedef struct packed {
    logic        lat0;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic        sel0;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;

  int compared   = 0;
  int mismatched = 0;

  vec_t vecs[$];

  dmem_responder_if bus2();
  dmem_responder_if bus0();

  assign bus2.memreq   = req & ~sel0;
  assign bus2.memwrite = we;
  assign bus2.addr     = addr;
  assign bus2.wdata    = wdata;
  assign bus2.be       = be;

  assign bus0.memreq   = req & sel0;
  assign bus0.memwrite = we;
  assign bus0.addr     = addr;
  assign bus0.wdata    = wdata;
  assign bus0.be       = be;

  dmem_responder #(.DEPTH(64), .LATENCY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  dmem_responder #(.DEPTH(64), .LATENCY(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  logic        obs_ready;
  logic        obs_stall;
  logic        obs_err;
  logic [31:0] obs_rdata;

  assign obs_ready = sel0 ? bus0.ready : bus2.ready;
  assign obs_stall = sel0 ? bus0.stall : bus2.stall;
  assign obs_err   = sel0 ? bus0.err   : bus2.err;
  assign obs_rdata = sel0 ? bus0.rdata : bus2.rdata;

  always #5 clk = ~clk;

  task automatic checkOutput(input string what, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", what, actual, expected);
    end
  endtask

  task automatic addVec(input logic lat0, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.lat0      = lat0;
    v.wr        = wr;
    v.a         = a;
    v.d         = d;
    v.b         = b;
    v.exp_rdata = exp_rdata;
    v.exp_err   = exp_err;
    vecs.push_back(v);
  endtask

  // Runs one transaction with memreq held until ready, checking latency,
  // stall profile and response contents.
  task automatic applyStimulus(input vec_t v, input int tag);
    int cycles;
    int stall_high;
    bit seen;
    cycles     = 0;
    stall_high = 0;
    seen       = 1'b0;
    @(negedge clk);
    sel0  = v.lat0;
    we    = v.wr;
    addr  = v.a;
    wdata = v.d;
    be    = v.b;
    req   = 1'b1;
    while (!seen && cycles < 20) begin
      #1;
      cycles++;
      if (obs_ready === 1'b1) begin
        seen = 1'b1;
        checkOutput($sformatf("v%0d stall in ready cycle", tag), 32'(obs_stall), 32'd0);
      end else begin
        if (obs_stall === 1'b1) stall_high++;
        @(negedge clk);
      end
    end
    checkOutput($sformatf("v%0d ready seen", tag), 32'(seen), 32'd1);
    checkOutput($sformatf("v%0d latency", tag), 32'(cycles), v.lat0 ? 32'd2 : 32'd4);
    checkOutput($sformatf("v%0d stall cycles", tag), 32'(stall_high), v.lat0 ? 32'd1 : 32'd3);
    checkOutput($sformatf("v%0d rdata", tag), obs_rdata, v.exp_rdata);
    checkOutput($sformatf("v%0d err", tag), 32'(obs_err), 32'(v.exp_err));
    req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;
    vec_t v;

    // Vector table: LATENCY=2 instance unless lat0 is set.
    addVec(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0);
    addVec(1'b0, 1'b0, 32'h10, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0);
    addVec(1'b0, 1'b1, 32'h08, 32'h11223344, 4'hF, 32'h11223344, 1'b0);
    addVec(1'b0, 1'b1, 32'h08, 32'hAABBCCDD, 4'h5, 32'h11BB33DD, 1'b0);
    addVec(1'b0, 1'b0, 32'h08, 32'h0,        4'h0, 32'h11BB33DD, 1'b0);
    addVec(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 1'b0);
    addVec(1'b0, 1'b1, 32'hFC, 32'h01020304, 4'hF, 32'h01020304, 1'b0);
    addVec(1'b0, 1'b1, 32'hFC, 32'hA0B0C0D0, 4'hA, 32'hA002C004, 1'b0);
    addVec(1'b0, 1'b0, 32'h20, 32'hFFFFFFFF, 4'h0, 32'hCAFEF00D, 1'b0);
    addVec(1'b0, 1'b1, 32'h00, 32'h0F0F0F0F, 4'hF, 32'h0F0F0F0F, 1'b0);
    addVec(1'b1, 1'b1, 32'h08, 32'h0BADCAFE, 4'hF, 32'h0BADCAFE, 1'b0);
    addVec(1'b1, 1'b0, 32'h08, 32'h0,        4'hF, 32'h0BADCAFE, 1'b0);
`ifdef DMEM_ERR_EN
    addVec(1'b0, 1'b0, 32'h102, 32'h0,        4'hF, 32'h00000000, 1'b1);
    addVec(1'b0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 32'h00000000, 1'b1);
    addVec(1'b0, 1'b1, 32'h01,  32'hEEEEEEEE, 4'hF, 32'h00000000, 1'b1);
    addVec(1'b0, 1'b0, 32'h00,  32'h0,        4'hF, 32'h0F0F0F0F, 1'b0);
`else
    addVec(1'b0, 1'b0, 32'h12,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0);
    addVec(1'b0, 1'b0, 32'h110, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0);
    addVec(1'b1, 1'b1, 32'h104, 32'h13579BDF, 4'hF, 32'h13579BDF, 1'b0);
    addVec(1'b1, 1'b0, 32'h004, 32'h0,        4'hF, 32'h13579BDF, 1'b0);
`endif

    // Reset state, and stall following memreq while reset is held.
    reset = 1'b0;
    req   = 1'b0;
    sel0  = 1'b0;
    we    = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    be    = 4'h0;
    repeat (2) @(negedge clk);
    checkOutput("reset ready", 32'(bus2.ready), 32'd0);
    checkOutput("reset rdata", bus2.rdata, 32'd0);
    checkOutput("reset err", 32'(bus2.err), 32'd0);
    req = 1'b1;
    #1;
    checkOutput("stall follows memreq in reset", 32'(bus2.stall), 32'd1);
    req = 1'b0;
    #1;
    checkOutput("stall low without memreq", 32'(bus2.stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] running %0d table vectors", vecs.size());
    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // memreq dropped right after capture: the store still completes on time.
    @(negedge clk);
    sel0  = 1'b0;
    we    = 1'b1;
    addr  = 32'h30;
    wdata = 32'h5A5A5A5A;
    be    = 4'hF;
    req   = 1'b1;
    cycles = 1;
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      cycles++;
      if (bus2.ready === 1'b1) break;
      @(negedge clk);
    end
    checkOutput("drop latency", 32'(cycles), 32'd4);
    checkOutput("drop ready", 32'(bus2.ready), 32'd1);
    checkOutput("drop rdata", bus2.rdata, 32'h5A5A5A5A);
    @(negedge clk);
    #1;
    checkOutput("ready one cycle", 32'(bus2.ready), 32'd0);
    checkOutput("rdata holds", bus2.rdata, 32'h5A5A5A5A);
    v = '{lat0: 1'b0, wr: 1'b0, a: 32'h30, d: 32'h0, b: 4'hF,
          exp_rdata: 32'h5A5A5A5A, exp_err: 1'b0};
    applyStimulus(v, 100);

    // Reset during WAIT of a store to 0x20 aborts it.
    @(negedge clk);
    sel0  = 1'b0;
    we    = 1'b1;
    addr  = 32'h20;
    wdata = 32'h12345678;
    be    = 4'hF;
    req   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort ready", 32'(bus2.ready), 32'd0);
    checkOutput("abort err", 32'(bus2.err), 32'd0);
    checkOutput("abort rdata", bus2.rdata, 32'd0);
    req = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("no ready after abort", 32'(bus2.ready), 32'd0);
    reset = 1'b1;
    v = '{lat0: 1'b0, wr: 1'b0, a: 32'h20, d: 32'h0, b: 4'hF,
          exp_rdata: 32'hCAFEF00D, exp_err: 1'b0};
    applyStimulus(v, 101);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
